// File: rtl/rom_load_sequencer.sv
// Routes HPS ioctl download bytes into the main/sound ROM regions, captures game-select and DIP bytes,
// throttles the host with ioctl_wait while a ROM write is outstanding, and holds the boards in reset around a download.
module rom_load_sequencer #(
  parameter int unsigned ADDR_W      = 17,
  parameter logic [24:0] MAIN_BASE   = 25'h00000,
  parameter logic [24:0] MAIN_SIZE   = 25'h1A000,
  parameter logic [24:0] SND_BASE    = 25'h1A000,
  parameter logic [24:0] SND_SIZE    = 25'h01000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              main_wr,
  output logic              snd_wr,
  input  logic              main_ack,
  input  logic              snd_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [7:0]        mod,
  output logic [63:0]       dip_sw,
  output logic              core_reset,
  output logic              load_done,
  output logic              err_addr,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK, S_HOLD} state_t;

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > HOLD_CYCLES) ? ACK_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sel_snd_q, sel_snd_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [7:0]          rom_data_q, rom_data_d;
  logic                load_done_q, load_done_d;
  logic                err_addr_q, err_addr_d;
  logic                err_timeout_q, err_timeout_d;
  logic                hold_pend_q, hold_pend_d;
  logic                dl_q, dl_d;
  logic                main_wr_q, main_wr_d;
  logic                snd_wr_q, snd_wr_d;
  logic                ioctl_wait_q, ioctl_wait_d;
  logic                core_reset_q, core_reset_d;
  // Board config survives an OSD reset; only power-up sets these.
  logic [7:0]          mod_q = 8'hFF;
  logic [7:0]          mod_d;
  logic [63:0]         dip_sw_q = 64'd0;
  logic [63:0]         dip_sw_d;

  logic [25:0] main_off, snd_off;
  logic        in_main, in_snd, dl_rise, dl_fall, tgt_ack;

  // A negative offset shows up in bit 25, so no separate lower-bound compare is needed.
  assign main_off = {1'b0, ioctl_addr} - {1'b0, MAIN_BASE};
  assign snd_off  = {1'b0, ioctl_addr} - {1'b0, SND_BASE};
  assign in_main  = ~main_off[25] && (main_off < {1'b0, MAIN_SIZE});
  assign in_snd   = ~snd_off[25] && (snd_off < {1'b0, SND_SIZE});
  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign tgt_ack  = sel_snd_q ? snd_ack : main_ack;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_snd_d     = sel_snd_q;
    rom_addr_d    = rom_addr_q;
    rom_data_d    = rom_data_q;
    load_done_d   = load_done_q;
    err_addr_d    = err_addr_q;
    err_timeout_d = err_timeout_q;
    mod_d         = mod_q;
    dip_sw_d      = dip_sw_q;
    dl_d          = ioctl_download;
    hold_pend_d   = hold_pend_q | dl_fall;

    if (dl_rise) begin
      load_done_d   = 1'b0;
      err_addr_d    = 1'b0;
      err_timeout_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ioctl_wr) begin
          if (ioctl_index == 8'd0) begin
            if (in_main) begin
              state_d    = S_WRITE;
              sel_snd_d  = 1'b0;
              rom_addr_d = main_off[ADDR_W-1:0];
              rom_data_d = ioctl_dout;
            end else if (in_snd) begin
              state_d    = S_WRITE;
              sel_snd_d  = 1'b1;
              rom_addr_d = snd_off[ADDR_W-1:0];
              rom_data_d = ioctl_dout;
            end else begin
              err_addr_d = 1'b1;
            end
          end else if (ioctl_index == 8'd1) begin
            mod_d = ioctl_dout;
          end else if (ioctl_index == 8'd254 && ioctl_addr[24:3] == '0) begin
            dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
          end
        end
        if (state_d == S_IDLE && hold_pend_d) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          hold_pend_d = 1'b0;
        end
      end
      S_WRITE: begin
        state_d = S_ACK;
        cnt_d   = '0;
      end
      S_ACK: begin
        if (tgt_ack || cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          if (!tgt_ack) err_timeout_d = 1'b1;
          // A download that ended mid-write goes straight into the settle period.
          if (hold_pend_d) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            hold_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        hold_pend_d = 1'b0;
        if (ioctl_download) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_IDLE;
          if (!err_addr_q && !err_timeout_q) load_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    main_wr_d    = (state_d == S_WRITE) && !sel_snd_d;
    snd_wr_d     = (state_d == S_WRITE) && sel_snd_d;
    ioctl_wait_d = (state_d == S_WRITE) || (state_d == S_ACK);
    core_reset_d = ioctl_download | hold_pend_d | (state_d == S_HOLD);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sel_snd_q     <= 1'b0;
      rom_addr_q    <= '0;
      rom_data_q    <= '0;
      load_done_q   <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      hold_pend_q   <= 1'b0;
      dl_q          <= 1'b0;
      main_wr_q     <= 1'b0;
      snd_wr_q      <= 1'b0;
      ioctl_wait_q  <= 1'b0;
      core_reset_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_snd_q     <= sel_snd_d;
      rom_addr_q    <= rom_addr_d;
      rom_data_q    <= rom_data_d;
      load_done_q   <= load_done_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      hold_pend_q   <= hold_pend_d;
      dl_q          <= dl_d;
      main_wr_q     <= main_wr_d;
      snd_wr_q      <= snd_wr_d;
      ioctl_wait_q  <= ioctl_wait_d;
      core_reset_q  <= core_reset_d;
      mod_q         <= mod_d;
      dip_sw_q      <= dip_sw_d;
    end
  end

  assign ioctl_wait  = ioctl_wait_q;
  assign main_wr     = main_wr_q;
  assign snd_wr      = snd_wr_q;
  assign rom_addr    = rom_addr_q;
  assign rom_data    = rom_data_q;
  assign mod         = mod_q;
  assign dip_sw      = dip_sw_q;
  assign core_reset  = core_reset_q;
  assign load_done   = load_done_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;

endmodule
